// File: rtl/row_mean_writer_pkg.sv
// Shared definitions for the row-mean writer: default image geometry, pixel width
// and the scan FSM state type.
package row_mean_writer_pkg;

    localparam int unsigned DefaultWidthBits  = 7;  // 128 columns
    localparam int unsigned DefaultHeightBits = 7;  // 128 rows
    localparam int unsigned DefaultWinBits    = 3;  // 8-tap window
    localparam int unsigned PixelBits         = 8;
    localparam int unsigned DefaultAddrWidth  = DefaultWidthBits + DefaultHeightBits;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/row_mean_writer_if.sv
// Control, source-read and middle-RAM-write bus of the row-mean writer.
//   iStart/oBusy/oDone       : start pulse and status
//   oRdcol/oRdrow/iRddata    : source read port (data one cycle after address)
//   oWren/oWrcol/oWrrow/oWrdata : middle RAM write port
// slave = the row-mean writer itself, master = the surrounding system.
interface row_mean_writer_if
    import row_mean_writer_pkg::*;
#(
    parameter int unsigned WIDTH_BITS  = DefaultWidthBits,
    parameter int unsigned HEIGHT_BITS = DefaultHeightBits
);
    logic                   iStart;
    logic                   oBusy;
    logic                   oDone;
    logic [WIDTH_BITS-1:0]  oRdcol;
    logic [HEIGHT_BITS-1:0] oRdrow;
    logic [PixelBits-1:0]   iRddata;
    logic                   oWren;
    logic [WIDTH_BITS-1:0]  oWrcol;
    logic [HEIGHT_BITS-1:0] oWrrow;
    logic [PixelBits-1:0]   oWrdata;

    modport slave (
        input  iStart, iRddata,
        output oBusy, oDone, oRdcol, oRdrow, oWren, oWrcol, oWrrow, oWrdata
    );

    modport master (
        output iStart, iRddata,
        input  oBusy, oDone, oRdcol, oRdrow, oWren, oWrcol, oWrrow, oWrdata
    );
endinterface

// File: rtl/row_mean_writer_sliding_window_sum.sv
// N-deep pixel history plus running sum for one row of the horizontal box filter.
//   clock, reset : clock and synchronous active-high reset
//   iValid       : a new sample is present on iData this cycle
//   iFirst       : the sample is the first of a row; restarts the window
//   iData        : sample value
//   oSum         : sum including this cycle's sample (the value registered at the edge)
//   oFull        : N samples of the current row are in the window, including this one
module row_mean_writer_sliding_window_sum
    import row_mean_writer_pkg::*;
#(
    parameter int unsigned WIN_BITS = DefaultWinBits
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          iValid,
    input  logic                          iFirst,
    input  logic [PixelBits-1:0]          iData,
    output logic [PixelBits+WIN_BITS-1:0] oSum,
    output logic                          oFull
);
    localparam int unsigned N  = 2 ** WIN_BITS;
    localparam int unsigned SW = PixelBits + WIN_BITS;
    localparam int unsigned FW = WIN_BITS + 1;

    logic [PixelBits-1:0] hist_q [N];
    logic [PixelBits-1:0] hist_d [N];
    logic [SW-1:0]        sum_q, sum_d;
    logic [FW-1:0]        fill_q, fill_d;

    always_comb begin
        hist_d = hist_q;
        sum_d  = sum_q;
        fill_d = fill_q;
        if (iValid) begin
            if (iFirst) begin
                // Zeroed history keeps the subtract path neutral while the row fills.
                for (int i = 0; i < N; i++) hist_d[i] = '0;
                hist_d[0] = iData;
                sum_d     = SW'(iData);
                fill_d    = FW'(1);
            end else begin
                sum_d = sum_q + SW'(iData) - SW'(hist_q[N-1]);
                for (int i = N - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
                hist_d[0] = iData;
                if (fill_q != FW'(N)) fill_d = fill_q + FW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N; i++) hist_q[i] <= '0;
            sum_q  <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) hist_q[i] <= hist_d[i];
            sum_q  <= sum_d;
            fill_q <= fill_d;
        end
    end

    assign oSum  = sum_d;
    assign oFull = (fill_d == FW'(N));

endmodule

// File: rtl/row_mean_writer.sv
// Horizontal box-filter stage: scans the source image in raster order, reads W+N-1
// clamped columns per row and writes the N-tap mean of every column to the middle RAM.
//   clock, reset : clock and synchronous active-high reset
//   bus          : slave side of row_mean_writer_if (start/status, source read, RAM write)
// Pipeline: address in cycle n, pixel in n+1 (summed), registered write in n+2.
module row_mean_writer
    import row_mean_writer_pkg::*;
#(
    parameter int unsigned WIDTH_BITS  = DefaultWidthBits,
    parameter int unsigned HEIGHT_BITS = DefaultHeightBits,
    parameter int unsigned WIN_BITS    = DefaultWinBits
) (
    input logic              clock,
    input logic              reset,
    row_mean_writer_if.slave bus
);
    localparam int unsigned W    = 2 ** WIDTH_BITS;
    localparam int unsigned H    = 2 ** HEIGHT_BITS;
    localparam int unsigned N    = 2 ** WIN_BITS;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned KW   = WIDTH_BITS + 1;   // read index spans 0 .. W+N-2
    localparam int unsigned KMAX = W + N - 2;
    localparam int unsigned SW   = PixelBits + WIN_BITS;

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [HEIGHT_BITS-1:0] row_q, row_d;
    logic                   drain_q, drain_d;

    logic                   busy_q, done_q;
    logic [WIDTH_BITS-1:0]  rdcol_q;
    logic [HEIGHT_BITS-1:0] rdrow_q;

    // Stage aligned with iRddata.
    logic                   s1_valid, s1_first;
    logic [KW-1:0]          s1_k;
    logic [HEIGHT_BITS-1:0] s1_row;

    logic                   wren_q;
    logic [WIDTH_BITS-1:0]  wrcol_q;
    logic [HEIGHT_BITS-1:0] wrrow_q;
    logic [PixelBits-1:0]   wrdata_q;

    logic [SW-1:0]          win_sum;
    logic                   win_full;

    function automatic logic [WIDTH_BITS-1:0] clamp_col(input logic [KW-1:0] k);
        logic [KW-1:0] x;
        if (k < KW'(HALF)) return '0;
        x = k - KW'(HALF);
        if (x > KW'(W - 1)) return '1;
        return x[WIDTH_BITS-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        row_d   = row_q;
        drain_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.iStart) begin
                    state_d = StRun;
                    k_d     = '0;
                    row_d   = '0;
                end
            end
            StRun: begin
                if (k_q == KW'(KMAX)) begin
                    k_d   = '0;
                    row_d = row_q + HEIGHT_BITS'(1);  // wraps to 0 after the last row
                    if (row_q == HEIGHT_BITS'(H - 1)) state_d = StDrain;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) state_d = StDone;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    row_mean_writer_sliding_window_sum #(
        .WIN_BITS(WIN_BITS)
    ) u_window (
        .clock (clock),
        .reset (reset),
        .iValid(s1_valid),
        .iFirst(s1_first),
        .iData (bus.iRddata),
        .oSum  (win_sum),
        .oFull (win_full)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            row_q    <= '0;
            drain_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdcol_q  <= '0;
            rdrow_q  <= '0;
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_k     <= '0;
            s1_row   <= '0;
            wren_q   <= 1'b0;
            wrcol_q  <= '0;
            wrrow_q  <= '0;
            wrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            row_q    <= row_d;
            drain_q  <= drain_d;
            busy_q   <= (state_d == StRun) || (state_d == StDrain);
            done_q   <= (state_d == StDone);
            rdcol_q  <= clamp_col(k_d);
            rdrow_q  <= row_d;
            s1_valid <= (state_q == StRun);
            s1_first <= (k_q == '0);
            s1_k     <= k_q;
            s1_row   <= row_q;
            wren_q   <= s1_valid && win_full;
            if (s1_valid && win_full) begin
                wrcol_q  <= WIDTH_BITS'(s1_k - KW'(N - 1));
                wrrow_q  <= s1_row;
                wrdata_q <= PixelBits'(win_sum >> WIN_BITS);
            end
        end
    end

    assign bus.oBusy   = busy_q;
    assign bus.oDone   = done_q;
    assign bus.oRdcol  = rdcol_q;
    assign bus.oRdrow  = rdrow_q;
    assign bus.oWren   = wren_q;
    assign bus.oWrcol  = wrcol_q;
    assign bus.oWrrow  = wrrow_q;
    assign bus.oWrdata = wrdata_q;

endmodule
